// File: rtl/dm_port_arbiter_pkg.sv
// Shared constants, state encoding and request payload for the data-memory port arbiter.
package dm_port_arbiter_pkg;

   localparam int unsigned DM_ADDR_W     = 11;
   localparam int unsigned DM_STARVE_MAX = 4;
   localparam int unsigned DM_CNT_W      = 3;
   localparam int unsigned DM_DATA_W     = 32;
   localparam int unsigned DM_BE_W       = 4;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_RD_C = 2'd1,
      ARB_RD_U = 2'd2
   } arb_state_e;

   // One requester's access: lane-aligned byte enables (0 = read), byte address, right-justified data.
   typedef struct packed {
      logic [DM_BE_W-1:0]   be;
      logic [31:0]          addr;
      logic [DM_DATA_W-1:0] wd;
   } dm_req_t;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Requester-side handshake for one arbiter port (CPU M-stage or UART loader).
interface dm_port_arbiter_if;
   import dm_port_arbiter_pkg::*;

   logic                 req;
   dm_req_t              pl;
   logic                 gnt;
   logic                 stall;
   logic                 rvalid;
   logic [DM_DATA_W-1:0] rd;

   modport master (output req, pl, input gnt, stall, rvalid, rd);
   modport slave  (input req, pl, output gnt, stall, rvalid, rd);

endinterface

// File: rtl/dm_port_arbiter_lane_align.sv
// Shifts right-justified write data onto the byte lane selected by addr[1:0].
module dm_port_arbiter_lane_align
   import dm_port_arbiter_pkg::*;
(
   input  logic [DM_DATA_W-1:0] wd,
   input  logic [1:0]           lane,
   output logic [DM_DATA_W-1:0] dina
);

   assign dina = wd << {lane, 3'b000};

endmodule

// File: rtl/dm_port_arbiter.sv
// Single-port data RAM arbiter: CPU fixed priority, UART starvation bound, 1-cycle read return routing.
module dm_port_arbiter
   import dm_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = DM_ADDR_W,
   parameter int unsigned STARVE_MAX = DM_STARVE_MAX,
   parameter int unsigned CNT_W      = DM_CNT_W
)(
   input  logic                 clk,
   input  logic                 rst,
   dm_port_arbiter_if.slave     c,
   dm_port_arbiter_if.slave     u,
   output logic [DM_BE_W-1:0]   ram_wea,
   output logic [ADDR_W-1:0]    ram_addra,
   output logic [DM_DATA_W-1:0] ram_dina,
   input  logic [DM_DATA_W-1:0] ram_douta
);

   arb_state_e           state, state_next;
   logic [CNT_W-1:0]     starve_cnt, starve_cnt_next;
   logic                 c_gnt, u_gnt, any_gnt, u_force;
   logic [DM_BE_W-1:0]   win_be;
   logic [31:0]          win_addr;
   logic [DM_DATA_W-1:0] win_wd, aligned_wd;
   logic                 unused_addr;

   // State and starvation counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ARB_IDLE;
         starve_cnt <= '0;
      end else begin
         state      <= state_next;
         starve_cnt <= starve_cnt_next;
      end
   end

   // Grant, winner mux, read-return next state and starvation update
   always_comb begin
      state_next      = ARB_IDLE;
      starve_cnt_next = '0;
      c_gnt           = 1'b0;
      u_gnt           = 1'b0;
      win_be          = '0;
      win_addr        = '0;
      win_wd          = '0;
      u_force         = (starve_cnt == CNT_W'(STARVE_MAX));

      if (!rst) begin
         if (c.req && u.req) begin
            u_gnt = u_force;
            c_gnt = !u_force;
         end else begin
            c_gnt = c.req;
            u_gnt = u.req;
         end
      end

      if (c_gnt) begin
         win_be   = c.pl.be;
         win_addr = c.pl.addr;
         win_wd   = c.pl.wd;
      end else if (u_gnt) begin
         win_be   = u.pl.be;
         win_addr = u.pl.addr;
         win_wd   = u.pl.wd;
      end

      if (c_gnt && (c.pl.be == '0))
         state_next = ARB_RD_C;
      else if (u_gnt && (u.pl.be == '0))
         state_next = ARB_RD_U;

      // Counter only survives while U keeps asking and keeps losing
      if (u.req && !u_gnt)
         starve_cnt_next = u_force ? starve_cnt : starve_cnt + CNT_W'(1);
   end

   assign any_gnt = c_gnt | u_gnt;

   dm_port_arbiter_lane_align u_lane_align (
      .wd   (win_wd),
      .lane (win_addr[1:0]),
      .dina (aligned_wd)
   );

   assign ram_wea     = win_be;
   assign ram_addra   = win_addr[ADDR_W+1:2];
   assign ram_dina    = any_gnt ? aligned_wd : '0;
   assign unused_addr = ^win_addr[31:ADDR_W+2];

   assign c.gnt    = c_gnt;
   assign c.stall  = c.req & ~c_gnt & ~rst;
   assign c.rvalid = (state == ARB_RD_C) & ~rst;
   assign c.rd     = c.rvalid ? ram_douta : '0;

   assign u.gnt    = u_gnt;
   assign u.stall  = u.req & ~u_gnt & ~rst;
   assign u.rvalid = (state == ARB_RD_U) & ~rst;
   assign u.rd     = u.rvalid ? ram_douta : '0;

endmodule
